// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: request/address out of fetch, ack/data back.
interface instruction_fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [23:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks the PC, issues memory reads, holds one
// instruction for decode, handles redirects (with drain of an in-flight
// read) and stops on a HALT opcode until redirected.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [15:0]         branch_target,
    instruction_fetch_if.master imem,
    output logic [23:0]         instruction,
    output logic                instr_valid,
    output logic [15:0]         pc_out,
    output logic                halted
);

    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] drain_addr;
    logic        pending;
    logic        req;
    logic        capture;

    // Request generation: reads are issued only while the output slot can be
    // refilled; a drain keeps the abandoned read alive until memory answers.
    always_comb begin
        req = 1'b0;
        case (state)
            FETCH:   req = (!instr_valid || !stall) && !branch_taken;
            DRAIN:   req = 1'b1;
            default: req = 1'b0;
        endcase
        if (rst) begin
            req = 1'b0;
        end
    end

    assign capture        = (state == FETCH) && req && imem.imem_ack;
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

    // Fetch state machine, PC and the registered instruction slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            pending     <= 1'b0;
            instruction <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                        pending     <= 1'b0;
                        // An unanswered read must be soaked up before refetching.
                        if (pending && !imem.imem_ack) begin
                            state      <= DRAIN;
                            drain_addr <= pc;
                        end
                    end else if (capture) begin
                        instruction <= imem.imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 16'd1;
                        pending     <= 1'b0;
                        if (imem.imem_rdata[23:18] == HALT_OPCODE) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end else begin
                        pending <= req;
                        if (!stall) begin
                            instr_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end
                    if (imem.imem_ack) begin
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                        halted      <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, with a transaction-level reference model and memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [23:0] instruction;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic        halted;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem         (bus.master),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: next fetch address, the delivered word, halt flag.
    logic [15:0] m_pc;
    logic [15:0] m_pcout;
    logic [23:0] m_instr;
    logic        m_valid;
    logic        m_halted;

    // Memory model state.
    logic        outstanding;
    logic        discard;
    logic [15:0] hold_addr;
    int unsigned mem_cnt;
    int unsigned cur_lat;
    int unsigned fixed_lat;
    logic        rand_lat;
    logic        halt_en;
    logic [15:0] halt_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 24'hFC0000;
        return {8'h00, a};
    endfunction

    function automatic int unsigned next_lat();
        if (rand_lat) return $urandom_range(3, 0);
        return fixed_lat;
    endfunction

    task automatic model_reset();
        m_pc        = 16'h0000;
        m_pcout     = 16'h0000;
        m_instr     = 24'h0;
        m_valid     = 1'b0;
        m_halted    = 1'b0;
        outstanding = 1'b0;
        discard     = 1'b0;
        hold_addr   = 16'h0000;
        mem_cnt     = 0;
        cur_lat     = next_lat();
    endtask

    task automatic set_lat(input int unsigned l);
        rand_lat  = 1'b0;
        fixed_lat = l;
        cur_lat   = l;
        mem_cnt   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, 32'(instruction), 32'h0);
        check({tag, "_pcout"}, 32'(pc_out), 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_req"}, 32'(bus.imem_req), 32'h0);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'h0);
    endtask

    // One clock cycle: drive controls, check the request, answer it, check the result.
    task automatic cycle(input logic s, input logic b, input logic [15:0] t);
        logic        req_seen;
        logic        active;
        logic        ack;
        logic        deliver;
        logic [15:0] addr_seen;
        logic [15:0] ack_addr;
        @(negedge clk);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
        req_seen  = bus.imem_req;
        addr_seen = bus.imem_addr;
        if (discard)       check("req_drain", 32'(req_seen), 32'd1);
        else if (m_halted) check("req_halted", 32'(req_seen), 32'd0);
        else               check("req", 32'(req_seen), 32'((!m_valid || !s) && !b));
        if (req_seen) check("addr", 32'(addr_seen), 32'(outstanding ? hold_addr : m_pc));
        active   = req_seen || outstanding;
        ack      = active && (mem_cnt >= cur_lat);
        ack_addr = outstanding ? hold_addr : addr_seen;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(ack_addr) : 24'($urandom);
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        deliver = ack && !b && !discard;
        if (ack) begin
            mem_cnt = 0;
            cur_lat = next_lat();
        end else if (active) begin
            mem_cnt++;
        end
        if (b && outstanding && !ack) discard = 1'b1;
        else if (ack)                 discard = 1'b0;
        if (active && !ack && !outstanding) hold_addr = addr_seen;
        outstanding = active && !ack;
        if (b) begin
            m_pc     = t;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (deliver) begin
            check("fetch_pc", 32'(ack_addr), 32'(m_pc));
            m_pcout = m_pc;
            m_instr = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            if (m_instr[23:18] == 6'h3F) m_halted = 1'b1;
        end else if (!s) begin
            m_valid = 1'b0;
        end
        check("valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            check("pc_out", 32'(pc_out), 32'(m_pcout));
            check("instruction", 32'(instruction), 32'(m_instr));
        end
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    // Asynchronous reset pulse between edges, with a stray ack while in reset.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 24'hFC0000;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        bus.imem_ack = 1'b0;
        stall        = 1'b0;
        rst          = 1'b0;
        model_reset();
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 16'h0000;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 24'h0;
        halt_en        = 1'b0;
        halt_addr      = 16'h0003;
        rand_lat       = 1'b0;
        fixed_lat      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // zero-latency streaming from the reset PC
        repeat (8) cycle(1'b0, 1'b0, 16'h0);

        // three-cycle reads
        set_lat(2);
        repeat (13) cycle(1'b0, 1'b0, 16'h0);

        // stall with a live word at 5
        set_lat(0);
        cycle(1'b0, 1'b1, 16'h0005);
        cycle(1'b0, 1'b0, 16'h0);
        repeat (4) cycle(1'b1, 1'b0, 16'h0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0);

        // redirect during an outstanding read at 7
        set_lat(2);
        cycle(1'b0, 1'b1, 16'h0007);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0040);
        repeat (8) cycle(1'b0, 1'b0, 16'h0);

        // HALT at 3, then redirect out of it
        set_lat(0);
        halt_en = 1'b1;
        cycle(1'b0, 1'b1, 16'h0000);
        repeat (8) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0010);
        repeat (3) cycle(1'b0, 1'b0, 16'h0);
        halt_en = 1'b0;

        // PC wrap
        cycle(1'b0, 1'b1, 16'hFFFF);
        repeat (3) cycle(1'b0, 1'b0, 16'h0);

        // randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(9, 0) < 3), ($urandom_range(15, 0) == 0), 16'($urandom));
        end

        // reset mid-stall
        set_lat(0);
        cycle(1'b0, 1'b1, 16'h0005);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        reset_pulse();
        repeat (4) cycle(1'b0, 1'b0, 16'h0);

        // reset mid-request
        set_lat(3);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        reset_pulse();
        set_lat(0);
        repeat (4) cycle(1'b0, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
